// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter for a shared 16x16 read-only memory.
// Holds the address for WAIT+1 periods with mr_ low, then captures the word.
module mem_arbiter #(
  parameter int WAIT = 2
) (
  input  logic        clock,
  input  logic        reset_,
  input  logic        soc0,
  input  logic        soc1,
  input  logic [3:0]  addr0,
  input  logic [3:0]  addr1,
  output logic        eoc0,
  output logic        eoc1,
  output logic [15:0] data0,
  output logic [15:0] data1,
  output logic [3:0]  a3_a0,
  input  logic [15:0] d15_d0,
  output logic        mr_
);

  localparam int CW = (WAIT > 0) ? $clog2(WAIT + 1) : 1;
  localparam logic [CW-1:0] WAIT_C = CW'(WAIT);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RELEASE
  } state_t;

  state_t state, state_nxt;

  logic          last, last_nxt;
  logic          gnt, gnt_nxt;
  logic [CW-1:0] count, count_nxt;
  logic [3:0]    a3_a0_nxt;
  logic [15:0]   data0_nxt, data1_nxt;
  logic          eoc0_nxt, eoc1_nxt;
  logic          mr_nxt;

  logic q0, q1, pick, gnt_soc;

  assign q0      = soc0 & eoc0;
  assign q1      = soc1 & eoc1;
  // On a tie, favour the requester not served last.
  assign pick    = (q0 & q1) ? ~last : q1;
  assign gnt_soc = gnt ? soc1 : soc0;

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      state <= IDLE;
      last  <= 1'b1;
      gnt   <= 1'b0;
      count <= WAIT_C;
      a3_a0 <= 4'h0;
      data0 <= 16'h0000;
      data1 <= 16'h0000;
      eoc0  <= 1'b1;
      eoc1  <= 1'b1;
      mr_   <= 1'b1;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
      gnt   <= gnt_nxt;
      count <= count_nxt;
      a3_a0 <= a3_a0_nxt;
      data0 <= data0_nxt;
      data1 <= data1_nxt;
      eoc0  <= eoc0_nxt;
      eoc1  <= eoc1_nxt;
      mr_   <= mr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    gnt_nxt   = gnt;
    count_nxt = count;
    a3_a0_nxt = a3_a0;
    data0_nxt = data0;
    data1_nxt = data1;
    eoc0_nxt  = eoc0;
    eoc1_nxt  = eoc1;
    mr_nxt    = mr_;
    unique case (state)
      IDLE: begin
        if (q0 | q1) begin
          state_nxt = ACCESS;
          gnt_nxt   = pick;
          last_nxt  = pick;
          count_nxt = WAIT_C;
          mr_nxt    = 1'b0;
          if (pick) begin
            a3_a0_nxt = addr1;
            eoc1_nxt  = 1'b0;
          end else begin
            a3_a0_nxt = addr0;
            eoc0_nxt  = 1'b0;
          end
        end
      end
      ACCESS: begin
        if (count != '0) begin
          count_nxt = count - CW'(1);
        end else begin
          state_nxt = RELEASE;
          mr_nxt    = 1'b1;
          if (gnt) begin
            data1_nxt = d15_d0;
            eoc1_nxt  = 1'b1;
          end else begin
            data0_nxt = d15_d0;
            eoc0_nxt  = 1'b1;
          end
        end
      end
      RELEASE: begin
        if (!gnt_soc) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: WAIT=2 main instance plus a WAIT=0
// instance sharing the same requester stimulus.
module tb_mem_arbiter;

  logic        clock;
  logic        reset_;
  logic        soc0, soc1;
  logic [3:0]  addr0, addr1;

  logic        eoc0, eoc1, mr_;
  logic [15:0] data0, data1, d15_d0;
  logic [3:0]  a3_a0;

  logic        eoc0_z, eoc1_z, mr_z;
  logic [15:0] data0_z, data1_z, d_z;
  logic [3:0]  a_z;

  logic [15:0] mem [16];

  int checks = 0;
  int errors = 0;
  bit mon_en = 0;

  typedef struct {
    logic        req;
    logic [15:0] data;
  } exp_t;

  exp_t sbq[$];

  assign d15_d0 = mem[a3_a0];
  assign d_z    = mem[a_z];

  mem_arbiter #(.WAIT(2)) dut (
    .clock (clock),
    .reset_(reset_),
    .soc0  (soc0),
    .soc1  (soc1),
    .addr0 (addr0),
    .addr1 (addr1),
    .eoc0  (eoc0),
    .eoc1  (eoc1),
    .data0 (data0),
    .data1 (data1),
    .a3_a0 (a3_a0),
    .d15_d0(d15_d0),
    .mr_   (mr_)
  );

  mem_arbiter #(.WAIT(0)) dut_z (
    .clock (clock),
    .reset_(reset_),
    .soc0  (soc0),
    .soc1  (soc1),
    .addr0 (addr0),
    .addr1 (addr1),
    .eoc0  (eoc0_z),
    .eoc1  (eoc1_z),
    .data0 (data0_z),
    .data1 (data1_z),
    .a3_a0 (a_z),
    .d15_d0(d_z),
    .mr_   (mr_z)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #500000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%b exp=%b t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk16(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic req, input logic [15:0] data);
    exp_t e;
    e.req  = req;
    e.data = data;
    sbq.push_back(e);
  endtask

  task automatic pop(input logic req, input logic [15:0] data);
    exp_t e;
    if (sbq.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL sb_empty act=req%0d exp=none", req);
    end else begin
      e = sbq.pop_front();
      chk1("sb_req", req, e.req);
      chk16("sb_data", data, e.data);
    end
  endtask

  // Monitor: completions are rising eoc edges seen outside reset.
  initial begin
    logic p0, p1;
    p0 = 1'b1;
    p1 = 1'b1;
    forever begin
      @(negedge clock);
      if (mon_en) begin
        chk1("one_eoc_low", !eoc0 && !eoc1, 1'b0);
        chk1("mr_only_access", mr_, eoc0 & eoc1);
        if (reset_) begin
          if (eoc0 && !p0) pop(1'b0, data0);
          if (eoc1 && !p1) pop(1'b1, data1);
        end
      end
      p0 = eoc0;
      p1 = eoc1;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_ = 1'b0;
    soc0   = 1'b0;
    soc1   = 1'b0;
    tick();
    tick();
    reset_ = 1'b1;
  endtask

  task automatic wait_eoc(input bit sel, input logic val, input string name);
    int n;
    n = 0;
    while (((sel ? eoc1 : eoc0) !== val) && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL %s act=timeout exp=eoc%0d==%b", name, sel, val);
    end
  endtask

  initial begin
    int d0, d1, n;
    bit drop0, drop1;
    logic pe0, pe1;
    for (int i = 0; i < 16; i++) mem[i] = 16'(16'h0101 * i);
    mem[5] = 16'hA5C3;
    reset_ = 1'b0;
    soc0   = 1'b0;
    soc1   = 1'b0;
    addr0  = 4'h0;
    addr1  = 4'h0;
    tick();
    tick();
    chk1("rst_eoc0", eoc0, 1'b1);
    chk1("rst_eoc1", eoc1, 1'b1);
    chk1("rst_mr", mr_, 1'b1);
    chk16("rst_addr", {12'h0, a3_a0}, 16'h0);
    chk16("rst_data0", data0, 16'h0);
    chk16("rst_data1", data1, 16'h0);
    mon_en = 1'b1;

    // Single request, both WAIT=2 and WAIT=0 timing.
    reset_ = 1'b1;
    addr0  = 4'd5;
    soc0   = 1'b1;
    push(1'b0, 16'hA5C3);
    tick();
    chk1("single_k_eoc0", eoc0, 1'b0);
    chk1("single_k_mr", mr_, 1'b0);
    chk16("single_k_addr", {12'h0, a3_a0}, 16'h5);
    chk1("w0_k_eoc0", eoc0_z, 1'b0);
    tick();
    chk1("single_k1_eoc0", eoc0, 1'b0);
    chk1("single_k1_mr", mr_, 1'b0);
    chk1("w0_k1_eoc0", eoc0_z, 1'b1);
    chk1("w0_k1_mr", mr_z, 1'b1);
    chk16("w0_k1_data0", data0_z, 16'hA5C3);
    tick();
    chk1("single_k2_eoc0", eoc0, 1'b0);
    chk16("single_k2_addr", {12'h0, a3_a0}, 16'h5);
    tick();
    chk1("single_k3_eoc0", eoc0, 1'b1);
    chk1("single_k3_mr", mr_, 1'b1);
    chk16("single_k3_data0", data0, 16'hA5C3);
    soc0 = 1'b0;
    tick();
    tick();
    chk1("single_idle_eoc0", eoc0, 1'b1);

    // Simultaneous requests after reset: 0 first, then 1.
    do_reset();
    addr0 = 4'd2;
    addr1 = 4'd9;
    soc0  = 1'b1;
    soc1  = 1'b1;
    push(1'b0, 16'h0202);
    push(1'b1, 16'h0909);
    tick();
    chk1("sim_grant0_eoc0", eoc0, 1'b0);
    chk1("sim_grant0_eoc1", eoc1, 1'b1);
    chk16("sim_grant0_addr", {12'h0, a3_a0}, 16'h2);
    wait_eoc(1'b0, 1'b1, "sim_done0");
    chk1("sim_wait_eoc1", eoc1, 1'b1);
    soc0 = 1'b0;
    tick();
    chk1("sim_release_exit_eoc1", eoc1, 1'b1);
    tick();
    chk1("sim_grant1_eoc1", eoc1, 1'b0);
    chk16("sim_grant1_addr", {12'h0, a3_a0}, 16'h9);
    wait_eoc(1'b1, 1'b1, "sim_done1");
    chk16("sim_data1", data1, 16'h0909);
    chk16("sim_data0_kept", data0, 16'h0202);
    soc1 = 1'b0;
    tick();

    // Fairness: 8 transactions must alternate 0,1,0,1...
    do_reset();
    addr0 = 4'd3;
    addr1 = 4'd12;
    for (int i = 0; i < 4; i++) begin
      push(1'b0, 16'h0303);
      push(1'b1, 16'h0C0C);
    end
    soc0  = 1'b1;
    soc1  = 1'b1;
    drop0 = 1'b0;
    drop1 = 1'b0;
    pe0   = 1'b1;
    pe1   = 1'b1;
    d0    = 0;
    d1    = 0;
    n     = 0;
    while ((d0 < 4 || d1 < 4) && n < 200) begin
      tick();
      n++;
      if (drop0) begin
        drop0 = 1'b0;
        if (d0 < 4) soc0 = 1'b1;
      end else if (eoc0 && !pe0) begin
        soc0  = 1'b0;
        drop0 = 1'b1;
        d0++;
      end
      if (drop1) begin
        drop1 = 1'b0;
        if (d1 < 4) soc1 = 1'b1;
      end else if (eoc1 && !pe1) begin
        soc1  = 1'b0;
        drop1 = 1'b1;
        d1++;
      end
      pe0 = eoc0;
      pe1 = eoc1;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL fair_budget act=%0d/%0d exp=4/4", d0, d1);
    end
    soc0 = 1'b0;
    soc1 = 1'b0;
    tick();
    tick();

    // Address disturbance during ACCESS.
    do_reset();
    addr0 = 4'd7;
    addr1 = 4'd3;
    soc0  = 1'b1;
    push(1'b0, 16'h0707);
    tick();
    chk16("dist_grant_addr", {12'h0, a3_a0}, 16'h7);
    for (int i = 0; i < 2; i++) begin
      addr0 = ~addr0;
      addr1 = ~addr1;
      tick();
      chk16("dist_hold_addr", {12'h0, a3_a0}, 16'h7);
      chk1("dist_hold_mr", mr_, 1'b0);
    end
    addr0 = ~addr0;
    addr1 = ~addr1;
    tick();
    chk1("dist_cap_eoc0", eoc0, 1'b1);
    chk16("dist_cap_data0", data0, 16'h0707);
    soc0  = 1'b0;
    addr0 = 4'd11;
    tick();
    tick();
    chk16("idle_keep_addr", {12'h0, a3_a0}, 16'h7);

    // Reset in the middle of an access, then a full restart.
    do_reset();
    addr0 = 4'd2;
    soc0  = 1'b1;
    tick();
    chk1("abort_k_eoc0", eoc0, 1'b0);
    tick();
    reset_ = 1'b0;
    #1;
    chk1("abort_eoc0", eoc0, 1'b1);
    chk1("abort_mr", mr_, 1'b1);
    chk16("abort_addr", {12'h0, a3_a0}, 16'h0);
    chk16("abort_data0", data0, 16'h0);
    tick();
    reset_ = 1'b1;
    push(1'b0, 16'h0202);
    tick();
    chk1("restart_k_eoc0", eoc0, 1'b0);
    chk16("restart_k_addr", {12'h0, a3_a0}, 16'h2);
    tick();
    tick();
    chk1("restart_k2_eoc0", eoc0, 1'b0);
    tick();
    chk1("restart_k3_eoc0", eoc0, 1'b1);
    chk16("restart_data0", data0, 16'h0202);
    soc0 = 1'b0;
    tick();
    tick();
    tick();
    chk16("sb_drain", 16'(sbq.size()), 16'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter WAIT, default 2: extra clock periods the memory address is held stable before the data is captured.
REQ-002 clock  input  1  system clock; all state changes occur on the rising edge.
REQ-003 reset_  input  1  asynchronous, active-low reset.
REQ-004 soc0, soc1  input  1 each  start-of-cycle request from requester 0 / requester 1.
REQ-005 addr0, addr1  input  4 each  word address from requester 0 / requester 1; held stable while the matching soc is 1.
REQ-006 eoc0, eoc1  output  1 each  end-of-cycle handshake to requester 0 / requester 1.
REQ-007 data0, data1  output  16 each  read word returned to requester 0 / requester 1.
REQ-008 a3_a0  output  4  address to the shared 16x16 memory.
REQ-009 d15_d0  input  16  data from the shared memory, combinational in a3_a0.
REQ-010 mr_  output  1  memory read strobe, active low.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, ACCESS and RELEASE.
REQ-012 The block SHALL use a 1-bit register LAST that holds the index of the most recently granted requester.
REQ-013 In IDLE, a grant SHALL be made only to requester i with soci==1 and eoci==1.
REQ-014 If both requesters qualify in IDLE in the same cycle, the block SHALL grant the requester whose index differs from LAST (round-robin).
REQ-015 On the grant edge k, the block SHALL: latch addri into a3_a0; set eoci=0; set mr_=0; load COUNT=WAIT; set LAST=i; record i as the current grantee; go to ACCESS.
REQ-016 In ACCESS with COUNT!=0, the block SHALL decrement COUNT and hold a3_a0 and mr_.
REQ-017 In ACCESS with COUNT==0, the block SHALL in one edge: set datai<=d15_d0; set eoci=1; set mr_=1; go to RELEASE.
REQ-018 Capture SHALL occur at edge k+WAIT+1, so the address is stable for WAIT+1 periods before capture.
REQ-019 In RELEASE, the block SHALL stay until the grantee's soci==0, then go to IDLE.
REQ-020 No new grant SHALL be made in the RELEASE exit cycle.
REQ-021 A non-granted requester's soc SHALL be ignored until IDLE, and its eoc, data and address SHALL be left unchanged.
REQ-022 a3_a0 SHALL keep its last value outside ACCESS.
REQ-023 datai SHALL keep its last captured value until requester i's next capture.
REQ-024 Changes on a non-granted requester's addr, or on the grantee's addr after the grant, SHALL have no effect on a3_a0.
REQ-025 A requester that raises soc while the other is in ACCESS SHALL be granted on the first IDLE cycle in which its soc is still 1.
REQ-026 COUNT SHALL be wide enough for WAIT.
REQ-027 When WAIT==0, capture SHALL occur on the edge after the grant.
REQ-028 At most one eoc SHALL be 0 at any time.
REQ-029 mr_ SHALL be 0 only in ACCESS.

Reset
REQ-030 While reset_==0, the block SHALL hold, independently of clock: state=IDLE, LAST=1, COUNT=WAIT, a3_a0=0, data0=data1=0, eoc0=eoc1=1, mr_=1.
REQ-031 Reset asserted during ACCESS or RELEASE SHALL abort the access immediately, with no capture and no data update.
REQ-032 After reset_ rises, the first grant SHALL be evaluated on the next rising edge.

Verification
REQ-033 Single request, WAIT=2: soc0=1, addr0=5, mem[5]=16'hA5C3 -> eoc0 falls at edge k; a3_a0=5 and mr_=0 for edges k..k+2; at edge k+3 data0=16'hA5C3, eoc0=1, mr_=1; soc0 dropped -> IDLE.
REQ-034 Simultaneous requests after reset: soc0=soc1=1, addr0=2, addr1=9 -> requester 0 is served first; requester 1 is granted on the first IDLE cycle after soc0 falls; data1=mem[9]; eoc1 stays 1 until its grant.
REQ-035 Fairness: both requesters re-request continuously, dropping soc for one cycle after each eoc -> grants alternate 0,1,0,1 over 8 transactions.
REQ-036 Address disturbance: during ACCESS for requester 0, toggle addr0 and addr1 every cycle -> a3_a0 stays at the latched value; data0 equals mem[latched address].
REQ-037 Reset mid-access: reset_=0 at edge k+1 of an access -> eoc0=1, mr_=1, a3_a0=0 immediately; data0 is unchanged; after release, soc0=1 restarts a full WAIT+1 access.
REQ-038 Run REQ-033 with WAIT=0 -> capture occurs at edge k+1.
